dmem_loader: RTL

- Sequential front-end that fills data memory with operand words from a valid/ready stream, kicks the core, and waits for completion.
- Drives the data-memory write path (current_addr, write_from_tb, mem_data) and the address-mux select of the multicore top, replacing direct testbench writes.
- Generates the core START pulse and consumes the core END.
- Sits directly upstream of the top-level data memory and core.

---
 rtl/dmem_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dmem_loader.sv
// dmem_loader: fills data memory from a valid/ready word stream, pulses the
// core START, then waits for the core END (optionally bounded by a watchdog).
//
// Optional feature macro: LOADER_TIMEOUT_EN (RUN watchdog of TIMEOUT_CYCLES).
//
// Ports:
//   clk_i             system clock, rising edge
//   rst_ni            asynchronous active-low reset
//   load_start_i      one-cycle request to start a load/run sequence
//   base_addr_i       first data-memory address to write
//   word_count_i      number of words to load
//   in_valid_i        stream word valid
//   in_data_i         stream word
//   in_ready_o        loader accepts a word this cycle (LOAD only)
//   current_addr_o    data-memory write address (registered)
//   mem_data_o        data-memory write data (registered)
//   write_from_tb_o   data-memory write enable (registered)
//   addr_mux_select_o 00 core, 01 loader write, 10 readback
//   start_o           core start pulse (KICK state)
//   end_i             core completion
//   busy_o            high in LOAD, FLUSH, KICK, RUN
//   done_o            one-cycle completion pulse
//   words_written_o   words written in the current sequence
//   timeout_o         watchdog expired, sticky until next load_start
module dmem_loader #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [15:0]       word_count_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic [ADDR_W-1:0] current_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              write_from_tb_o,
   output logic [1:0]        addr_mux_select_o,
   output logic              start_o,
   input  logic              end_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [15:0]       words_written_o,
   output logic              timeout_o
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] FLUSH = 3'd2;
   localparam logic [2:0] KICK  = 3'd3;
   localparam logic [2:0] RUN   = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [15:0]       rem_q, rem_d, ww_q, ww_d;
   logic              wr_q, wr_d, done_q, done_d, to_q, to_d;
   logic              hs, expire;

   assign hs = in_valid_i & in_ready_o;

`ifdef LOADER_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   // cnt_q counts completed RUN cycles, so expiry fires during the
   // TIMEOUT_CYCLES-th RUN cycle; END in that same cycle takes priority.
   assign expire = (state_q == RUN) && !end_i && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
   assign cnt_d  = (state_q == KICK) ? 16'd0 : (state_q == RUN) ? cnt_q + 16'd1 : cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      ww_d    = ww_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wr_d    = hs;
      done_d  = 1'b0;
      to_d    = to_q;
      if (hs) begin
         addr_d = ptr_q;
         data_d = in_data_i;
         ptr_d  = ptr_q + 1'b1;
         rem_d  = rem_q - 16'd1;
         ww_d   = ww_q + 16'd1;
         if (rem_q == 16'd1) state_d = FLUSH;
      end
      case (state_q)
         IDLE, DONE: if (load_start_i) begin
            ptr_d   = base_addr_i;
            rem_d   = word_count_i;
            ww_d    = '0;
            to_d    = 1'b0;
            state_d = (word_count_i == 16'd0) ? KICK : LOAD;
         end
         LOAD:  ;
         FLUSH: state_d = KICK;
         KICK:  state_d = RUN;
         RUN: if (end_i || expire) begin
            state_d = DONE;
            done_d  = 1'b1;
            to_d    = expire;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         ww_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         ww_q    <= ww_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         done_q  <= done_d;
         to_q    <= to_d;
      end
   end

   assign in_ready_o        = (state_q == LOAD);
   assign current_addr_o    = addr_q;
   assign mem_data_o        = data_q;
   assign write_from_tb_o   = wr_q;
   assign addr_mux_select_o = (state_q == DONE) ? 2'b10 :
                              (state_q == LOAD || state_q == FLUSH) ? 2'b01 : 2'b00;
   assign start_o           = (state_q == KICK);
   assign busy_o            = (state_q == LOAD) || (state_q == FLUSH) ||
                              (state_q == KICK) || (state_q == RUN);
   assign done_o            = done_q;
   assign words_written_o   = ww_q;
   assign timeout_o         = to_q;
endmodule
